// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer and status controller for the dual-clock FIFO.
// Keeps binary/Gray read pointers and registered empty, almost-empty, level and underflow status.
module rptr_empty_ctrl #(
   parameter int ADDR_WIDTH    = 9,
   parameter int AEMPTY_THRESH = 4
) (
   input  logic                  r_clk,
   input  logic                  rrst,
   input  logic                  r_en,
   input  logic                  err_clr,
   input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
   output logic [ADDR_WIDTH-1:0] raddr,
   output logic [ADDR_WIDTH:0]   rptr_gray,
   output logic                  r_ack,
   output logic                  f_empty,
   output logic                  f_aempty,
   output logic [ADDR_WIDTH:0]   rd_level,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

   logic [ADDR_WIDTH:0] rptr_bin;
   logic [ADDR_WIDTH:0] rbin_next;
   logic [ADDR_WIDTH:0] rgray_next;
   logic [ADDR_WIDTH:0] wbin_sync;
   logic [ADDR_WIDTH:0] level_next;

   assign r_ack = r_en && !f_empty;
   assign raddr = rptr_bin[ADDR_WIDTH-1:0];

   // Next pointer and level; the level folds in this cycle's accepted read so it never over-reports
   always_comb begin
      rbin_next  = rptr_bin + {{ADDR_WIDTH{1'b0}}, r_ack};
      rgray_next = (rbin_next >> 1) ^ rbin_next;
      wbin_sync  = '0;
      for (int i = 0; i <= ADDR_WIDTH; i++) begin
         wbin_sync[i] = ^(wptr_gray_sync >> i);
      end
      level_next = wbin_sync - rbin_next;
   end

   always_ff @(posedge r_clk or posedge rrst) begin
      if (rrst) begin
         rptr_bin  <= '0;
         rptr_gray <= '0;
         f_empty   <= 1'b1;
         f_aempty  <= 1'b1;
         rd_level  <= '0;
         underflow <= 1'b0;
      end else begin
         rptr_bin  <= rbin_next;
         rptr_gray <= rgray_next;
         f_empty   <= (rgray_next == wptr_gray_sync);
         f_aempty  <= (level_next <= AEMPTY_LVL);
         rd_level  <= level_next;
         // Setting takes priority so a read-while-empty in the clearing cycle is not lost
         if (r_en && f_empty) begin
            underflow <= 1'b1;
         end else if (err_clr) begin
            underflow <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Directed self-checking bench for rptr_empty_ctrl with a depth-8 FIFO and almost-empty threshold 2.
module tb_rptr_empty_ctrl;

   logic       r_clk;
   logic       rrst;
   logic       r_en;
   logic       err_clr;
   logic [3:0] wptr_gray_sync;
   logic [2:0] raddr;
   logic [3:0] rptr_gray;
   logic       r_ack;
   logic       f_empty;
   logic       f_aempty;
   logic [3:0] rd_level;
   logic       underflow;

   int n_checks = 0;
   int n_fail   = 0;

   rptr_empty_ctrl #(.ADDR_WIDTH(3), .AEMPTY_THRESH(2)) dut (
      .r_clk(r_clk), .rrst(rrst), .r_en(r_en), .err_clr(err_clr),
      .wptr_gray_sync(wptr_gray_sync), .raddr(raddr), .rptr_gray(rptr_gray),
      .r_ack(r_ack), .f_empty(f_empty), .f_aempty(f_aempty),
      .rd_level(rd_level), .underflow(underflow)
   );

   initial r_clk = 1'b0;
   always #5 r_clk = ~r_clk;

   function automatic logic [3:0] gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic tick();
      @(posedge r_clk);
      #1;
   endtask

   task automatic do_reset();
      rrst = 1'b1;
      r_en = 1'b0;
      err_clr = 1'b0;
      wptr_gray_sync = 4'b0000;
      tick();
      rrst = 1'b0;
   endtask

   task automatic test_reset();
      rrst = 1'b1;
      r_en = 1'b0;
      err_clr = 1'b0;
      wptr_gray_sync = 4'b0000;
      #1;
      n_checks++;
      if ({raddr, rptr_gray, f_empty, f_aempty, rd_level, underflow} !== {3'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL power_on_reset: got raddr=%0d gray=%b e=%b ae=%b lvl=%0d uf=%b", raddr, rptr_gray, f_empty, f_aempty, rd_level, underflow);
      end
      tick();
      rrst = 1'b0;
      wptr_gray_sync = gray(4'd3);
      r_en = 1'b1;
      tick();
      tick();
      n_checks++;
      if (raddr !== 3'd1 || underflow !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL pre_reset_activity: raddr=%0d uf=%b expected raddr=1 uf=1", raddr, underflow);
      end
      #4;
      rrst = 1'b1;
      #1;
      n_checks++;
      if ({raddr, rptr_gray, f_empty, f_aempty, rd_level, underflow} !== {3'd0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL async_reset: got raddr=%0d gray=%b e=%b ae=%b lvl=%0d uf=%b", raddr, rptr_gray, f_empty, f_aempty, rd_level, underflow);
      end
      r_en = 1'b0;
      wptr_gray_sync = 4'b0000;
      tick();
      rrst = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic [3:0] exp_lvl [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
      wptr_gray_sync = 4'b0111;
      tick();
      n_checks++;
      if (f_empty !== 1'b0 || rd_level !== 4'd5 || f_aempty !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL fill: e=%b lvl=%0d ae=%b expected e=0 lvl=5 ae=0", f_empty, rd_level, f_aempty);
      end
      for (int i = 0; i < 5; i++) begin
         r_en = 1'b1;
         #1;
         n_checks++;
         if (r_ack !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL drain_ack%0d: r_ack=%b expected 1", i, r_ack);
         end
         tick();
         n_checks++;
         if (rd_level !== exp_lvl[i] || f_aempty !== (exp_lvl[i] <= 4'd2) ||
             f_empty !== (i == 4) || raddr !== 3'(i + 1)) begin
            n_fail++;
            $display("[TB] FAIL drain%0d: lvl=%0d ae=%b e=%b raddr=%0d expected lvl=%0d ae=%b e=%b raddr=%0d",
                     i, rd_level, f_aempty, f_empty, raddr, exp_lvl[i], (exp_lvl[i] <= 4'd2), (i == 4), 3'(i + 1));
         end
      end
      r_en = 1'b0;
   endtask

   task automatic test_underflow();
      r_en = 1'b1;
      #1;
      n_checks++;
      if (r_ack !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL underflow_ack: r_ack=%b expected 0", r_ack);
      end
      tick();
      r_en = 1'b0;
      n_checks++;
      if (raddr !== 3'd5 || underflow !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL underflow_set: raddr=%0d uf=%b expected raddr=5 uf=1", raddr, underflow);
      end
      tick();
      n_checks++;
      if (underflow !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL underflow_sticky: uf=%b expected 1", underflow);
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_checks++;
      if (underflow !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL underflow_clear: uf=%b expected 0", underflow);
      end
      err_clr = 1'b1;
      r_en = 1'b1;
      tick();
      err_clr = 1'b0;
      r_en = 1'b0;
      n_checks++;
      if (underflow !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL underflow_set_wins: uf=%b expected 1", underflow);
      end
   endtask

   task automatic test_full_level();
      do_reset();
      wptr_gray_sync = 4'b1100;
      tick();
      n_checks++;
      if (rd_level !== 4'd8 || f_empty !== 1'b0 || f_aempty !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL full_level: lvl=%0d e=%b ae=%b expected lvl=8 e=0 ae=0", rd_level, f_empty, f_aempty);
      end
      n_checks++;
      if ((rptr_gray ^ wptr_gray_sync) !== 4'b1100) begin
         n_fail++;
         $display("[TB] FAIL full_gray_msbs: rptr_gray=%b wptr=%b expected differ in two MSBs only", rptr_gray, wptr_gray_sync);
      end
   endtask

   task automatic test_wrap_around();
      logic [3:0] wb, rb, exp_lvl, prev_gray;
      logic       exp_empty, exp_ack;
      logic [2:0] prev_raddr;
      int         reads, wraps_addr, wraps_ptr, cycles;
      do_reset();
      wb = 4'd0;
      rb = 4'd0;
      exp_lvl = 4'd0;
      exp_empty = 1'b1;
      reads = 0;
      wraps_addr = 0;
      wraps_ptr = 0;
      cycles = 0;
      while (reads < 20 && cycles < 200) begin
         if (4'(wb - rb) < 4'(1 + (cycles % 3))) wb = wb + 4'd1;
         wptr_gray_sync = gray(wb);
         r_en = 1'b1;
         exp_ack = !exp_empty;
         #1;
         n_checks++;
         if (r_ack !== exp_ack) begin
            n_fail++;
            $display("[TB] FAIL wrap_ack c%0d: r_ack=%b expected %b", cycles, r_ack, exp_ack);
         end
         prev_gray = rptr_gray;
         prev_raddr = raddr;
         if (exp_ack) begin
            rb = rb + 4'd1;
            reads++;
         end
         exp_lvl = wb - rb;
         exp_empty = (wb == rb);
         tick();
         cycles++;
         n_checks++;
         if (rd_level !== exp_lvl || f_empty !== exp_empty || f_aempty !== (exp_lvl <= 4'd2) ||
             raddr !== rb[2:0] || rptr_gray !== gray(rb)) begin
            n_fail++;
            $display("[TB] FAIL wrap_state c%0d: lvl=%0d e=%b ae=%b raddr=%0d gray=%b expected lvl=%0d e=%b ae=%b raddr=%0d gray=%b",
                     cycles, rd_level, f_empty, f_aempty, raddr, rptr_gray, exp_lvl, exp_empty, (exp_lvl <= 4'd2), rb[2:0], gray(rb));
         end
         if (exp_ack) begin
            n_checks++;
            if ($countones(prev_gray ^ rptr_gray) != 1) begin
               n_fail++;
               $display("[TB] FAIL wrap_gray_step c%0d: %b -> %b expected one bit change", cycles, prev_gray, rptr_gray);
            end
         end
         if (prev_raddr == 3'd7 && raddr == 3'd0) wraps_addr++;
         if (prev_gray == 4'b1000 && rptr_gray == 4'b0000) wraps_ptr++;
      end
      r_en = 1'b0;
      n_checks++;
      if (reads != 20) begin
         n_fail++;
         $display("[TB] FAIL wrap_timeout: reads=%0d expected 20", reads);
      end
      n_checks++;
      if (wraps_addr < 2 || wraps_ptr < 1) begin
         n_fail++;
         $display("[TB] FAIL wrap_seen: raddr wraps=%0d ptr wraps=%0d expected >=2 and >=1", wraps_addr, wraps_ptr);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      wptr_gray_sync = gray(4'd1);
      tick();
      n_checks++;
      if (rd_level !== 4'd1 || f_empty !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL simul_setup: lvl=%0d e=%b expected lvl=1 e=0", rd_level, f_empty);
      end
      r_en = 1'b1;
      wptr_gray_sync = gray(4'd2);
      #1;
      n_checks++;
      if (r_ack !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL simul_ack: r_ack=%b expected 1", r_ack);
      end
      tick();
      r_en = 1'b0;
      n_checks++;
      if (rd_level !== 4'd1 || f_empty !== 1'b0 || raddr !== 3'd1) begin
         n_fail++;
         $display("[TB] FAIL simul_result: lvl=%0d e=%b raddr=%0d expected lvl=1 e=0 raddr=1", rd_level, f_empty, raddr);
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_underflow();
      test_full_level();
      test_wrap_around();
      test_simultaneous();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
